// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the mode blocks.
//   - Glyph codes understood by the 7-segment driver (5 bits per digit).
//   - Controller state encoding.
//   - Default splash length (1 s at 100 MHz).
//   - Helper that builds the menu/splash display word.
package game_pkg;

    localparam logic [4:0] C_BLANK = 5'd31;
    localparam logic [4:0] C_P     = 5'd16;
    localparam logic [4:0] C_U     = 5'd15;
    localparam logic [4:0] C_d     = 5'd19;
    localparam logic [4:0] C_n     = 5'd20;
    localparam logic [4:0] C_g     = 5'd9;
    localparam logic [4:0] C_o     = 5'd17;

    localparam int DEFAULT_SPLASH_CYCLES = 100_000_000;

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_SPLASH = 2'd1,
        ST_RUN    = 2'd2,
        ST_EXIT   = 2'd3
    } ctrl_state_t;

    // "P _ _ n" where n is the 1-based mode number shown to the player.
    function automatic logic [19:0] menu_glyphs(input logic [3:0] sel);
        return {C_P, C_BLANK, C_BLANK, {1'b0, sel} + 5'd1};
    endfunction

endpackage

// File: rtl/mode_controller_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   level      : debounced button level
//   rise       : high for the cycle in which level is 1 and was 0 last cycle
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;

    // Previous-cycle copy of the button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/mode_controller.sv
// Top-level sequencer sharing LEDs, display and go/stop button between
// NUM_MODES game-mode blocks: menu -> splash -> run selected mode -> exit.
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   btn_next/enter/back : debounced button levels
//   mode_led_in         : 16-bit LED bus of each mode, mode k at [16k+15:16k]
//   mode_seg_in         : 20-bit display bus of each mode, mode k at [20k+19:20k]
//   mode_active         : one-hot run enable per mode (zero outside RUN)
//   mode_btn            : gated go/stop level per mode
//   led, seg_data       : registered board outputs
//   cur_mode            : selected mode index, 0-based
module mode_controller
    import game_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SPLASH_CYCLES = DEFAULT_SPLASH_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_next,
    input  logic                    btn_enter,
    input  logic                    btn_back,
    input  logic [16*NUM_MODES-1:0] mode_led_in,
    input  logic [20*NUM_MODES-1:0] mode_seg_in,
    output logic [NUM_MODES-1:0]    mode_active,
    output logic [NUM_MODES-1:0]    mode_btn,
    output logic [15:0]             led,
    output logic [19:0]             seg_data,
    output logic [2:0]              cur_mode
);

    localparam int              CW       = (SPLASH_CYCLES > 1) ? $clog2(SPLASH_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SPLASH_CYCLES - 1);
    localparam logic [3:0]      SEL_LAST = 4'(NUM_MODES - 1);

    logic next_rise_s;
    logic enter_rise_s;
    logic back_rise_s;

    ctrl_state_t          state_q, state_d;
    logic [3:0]           sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 arm_q, arm_d;
    logic [NUM_MODES-1:0] active_q, active_d;
    logic [NUM_MODES-1:0] mbtn_q, mbtn_d;
    logic [15:0]          led_q, led_d;
    logic [19:0]          seg_q, seg_d;

    logic [NUM_MODES-1:0] sel_onehot_s;
    logic [15:0]          sel_led_s;
    logic [19:0]          sel_seg_s;

    btn_edge u_next  (.clk(clk), .reset(reset), .level(btn_next),  .rise(next_rise_s));
    btn_edge u_enter (.clk(clk), .reset(reset), .level(btn_enter), .rise(enter_rise_s));
    btn_edge u_back  (.clk(clk), .reset(reset), .level(btn_back),  .rise(back_rise_s));

    // One-hot decode of the selection and AND-OR mux of the selected mode's buses.
    always_comb begin
        sel_onehot_s = '0;
        sel_led_s    = 16'h0000;
        sel_seg_s    = 20'h00000;
        for (int k = 0; k < NUM_MODES; k++) begin
            sel_onehot_s[k] = (sel_q == 4'(k));
            sel_led_s = sel_led_s | (mode_led_in[16*k +: 16] & {16{sel_onehot_s[k]}});
            sel_seg_s = sel_seg_s | (mode_seg_in[20*k +: 20] & {20{sel_onehot_s[k]}});
        end
    end

    // Next-state logic for the menu/splash/run/exit sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        arm_d   = arm_q;
        case (state_q)
            ST_MENU: begin
                // Enter beats a simultaneous next; back is ignored here.
                if (enter_rise_s) begin
                    state_d = ST_SPLASH;
                end else if (next_rise_s) begin
                    sel_d = (sel_q == SEL_LAST) ? 4'd0 : sel_q + 4'd1;
                end else begin
                    sel_d = sel_q;
                end
            end
            ST_SPLASH: begin
                // Back aborts even on the cycle the splash would expire.
                if (back_rise_s) begin
                    state_d = ST_MENU;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    arm_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                // Arm only after enter is seen low so the entering press never reaches the mode.
                if (back_rise_s) begin
                    state_d = ST_EXIT;
                end else begin
                    arm_d = arm_q | ~btn_enter;
                end
            end
            ST_EXIT: begin
                state_d = ST_MENU;
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // Registered outputs computed from the state being entered.
    always_comb begin
        active_d = '0;
        mbtn_d   = '0;
        led_d    = 16'h0000;
        seg_d    = menu_glyphs(sel_d);
        case (state_d)
            ST_MENU: begin
                led_d = 16'h0000;
            end
            ST_SPLASH: begin
                led_d = 16'hFFFF;
            end
            ST_RUN: begin
                active_d = sel_onehot_s;
                led_d    = sel_led_s;
                seg_d    = sel_seg_s;
                if ((state_q == ST_RUN) && arm_q && btn_enter) begin
                    mbtn_d = sel_onehot_s;
                end else begin
                    mbtn_d = '0;
                end
            end
            ST_EXIT: begin
                seg_d = {C_BLANK, C_BLANK, C_BLANK, C_BLANK};
            end
            default: begin
                led_d = 16'h0000;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_MENU;
            sel_q    <= 4'd0;
            cnt_q    <= '0;
            arm_q    <= 1'b0;
            active_q <= '0;
            mbtn_q   <= '0;
            led_q    <= 16'h0000;
            seg_q    <= {C_P, C_BLANK, C_BLANK, 5'd1};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            arm_q    <= arm_d;
            active_q <= active_d;
            mbtn_q   <= mbtn_d;
            led_q    <= led_d;
            seg_q    <= seg_d;
        end
    end

    assign mode_active = active_q;
    assign mode_btn    = mbtn_q;
    assign led         = led_q;
    assign seg_data    = seg_q;
    // The index never exceeds 8; the 3-bit port carries its low bits.
    assign cur_mode    = sel_q[2:0];

endmodule

// File: tb/tb_mode_controller.sv
module tb_mode_controller;

    localparam int NM = 4;
    localparam int SC = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_next, btn_enter, btn_back;
    logic [16*NM-1:0] mode_led_in;
    logic [20*NM-1:0] mode_seg_in;
    logic [NM-1:0] mode_active, mode_btn;
    logic [15:0]   led;
    logic [19:0]   seg_data;
    logic [2:0]    cur_mode;

    mode_controller #(.NUM_MODES(NM), .SPLASH_CYCLES(SC)) dut (
        .clk(clk), .reset(reset),
        .btn_next(btn_next), .btn_enter(btn_enter), .btn_back(btn_back),
        .mode_led_in(mode_led_in), .mode_seg_in(mode_seg_in),
        .mode_active(mode_active), .mode_btn(mode_btn),
        .led(led), .seg_data(seg_data), .cur_mode(cur_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic [19:0] seg;
        logic [3:0]  act;
        logic [3:0]  btn;
        logic [2:0]  cur;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    event  sample_ev;

    localparam logic [19:0] SEG_EXIT = 20'hFFFFF;
    localparam logic [19:0] SEG_M1   = 20'h12345;

    function automatic logic [19:0] menu_seg(input int s);
        logic [4:0] d;
        d = 5'(s + 1);
        return {5'd16, 5'd31, 5'd31, d};
    endfunction

    task automatic push(input string n, input logic [15:0] l, input logic [19:0] s,
                        input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        exp_t e;
        e.led = l; e.seg = s; e.act = a; e.btn = b; e.cur = c;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic step(input logic bn, input logic be, input logic bb);
        btn_next = bn; btn_enter = be; btn_back = bb;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented once per cycle; compare on the falling edge or on demand.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (led !== e.led || seg_data !== e.seg || mode_active !== e.act ||
                    mode_btn !== e.btn || cur_mode !== e.cur) begin
                    errors++;
                    $display("FAIL %s: got led=%h seg=%h act=%b btn=%b cur=%0d, want led=%h seg=%h act=%b btn=%b cur=%0d",
                             n, led, seg_data, mode_active, mode_btn, cur_mode,
                             e.led, e.seg, e.act, e.btn, e.cur);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        btn_next = 1'b0; btn_enter = 1'b0; btn_back = 1'b0;
        mode_led_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        mode_seg_in = {20'hFFFF0, 20'h0ABCD, 20'h12345, 20'h00001};
        #1 reset = 1'b1;
        #1 push("reset", 16'h0000, menu_seg(0), 4'b0000, 4'b0000, 3'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        step(1'b0, 1'b0, 1'b0);
        push("idle_menu", 16'h0000, menu_seg(0), 4'b0000, 4'b0000, 3'd0);

        // Five next presses: 1,2,3,0,1
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            push("next_sel", 16'h0000, menu_seg(i % NM), 4'b0000, 4'b0000, 3'(i % NM));
            step(1'b0, 1'b0, 1'b0);
        end

        // Enter mode index 1, holding enter through the splash
        step(1'b0, 1'b1, 1'b0);
        push("splash", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        for (int c = 2; c <= SC; c++) begin
            step(1'b0, 1'b1, 1'b0);
            push("splash", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        end
        step(1'b0, 1'b1, 1'b0);
        push("run_entry", 16'h2222, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        step(1'b0, 1'b1, 1'b0);
        push("run_held_unarmed", 16'h2222, SEG_M1, 4'b0010, 4'b0000, 3'd1);

        // New LED value on mode 1 appears one clock later
        mode_led_in[31:16] = 16'h5A5A;
        push("run_latency_old", 16'h2222, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        step(1'b0, 1'b1, 1'b0);
        push("run_latency_new", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);

        step(1'b0, 1'b0, 1'b0);
        push("run_arm", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        step(1'b0, 1'b1, 1'b0);
        push("run_go", 16'h5A5A, SEG_M1, 4'b0010, 4'b0010, 3'd1);
        step(1'b0, 1'b1, 1'b0);
        push("run_go_held", 16'h5A5A, SEG_M1, 4'b0010, 4'b0010, 3'd1);
        step(1'b0, 1'b0, 1'b0);
        push("run_stop", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);

        step(1'b0, 1'b0, 1'b1);
        push("exit", 16'h0000, SEG_EXIT, 4'b0000, 4'b0000, 3'd1);
        step(1'b0, 1'b0, 1'b0);
        push("exit_to_menu", 16'h0000, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        step(1'b0, 1'b0, 1'b1);
        push("menu_back_ignored", 16'h0000, menu_seg(1), 4'b0000, 4'b0000, 3'd1);

        // Abort the splash on its fifth cycle
        step(1'b0, 1'b1, 1'b0);
        push("abort_splash", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        for (int c = 2; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0);
            push("abort_splash", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        end
        step(1'b0, 1'b0, 1'b1);
        push("abort_menu", 16'h0000, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b0);
            push("abort_never_active", 16'h0000, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        end

        // Enter and next together: enter wins, selection kept
        step(1'b1, 1'b1, 1'b0);
        push("enter_wins", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        for (int c = 2; c <= SC; c++) begin
            step(1'b0, 1'b0, 1'b0);
            push("splash2", 16'hFFFF, menu_seg(1), 4'b0000, 4'b0000, 3'd1);
        end
        step(1'b0, 1'b0, 1'b0);
        push("run_entry2", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        step(1'b0, 1'b0, 1'b0);
        push("run_idle2", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        step(1'b0, 1'b1, 1'b1);
        push("back_wins_enter", 16'h0000, SEG_EXIT, 4'b0000, 4'b0000, 3'd1);
        step(1'b0, 1'b0, 1'b0);
        push("menu_after_exit2", 16'h0000, menu_seg(1), 4'b0000, 4'b0000, 3'd1);

        // Reach RUN again, then reset asynchronously mid-run
        step(1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= SC; c++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        push("run_entry3", 16'h5A5A, SEG_M1, 4'b0010, 4'b0000, 3'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 push("async_reset", 16'h0000, menu_seg(0), 4'b0000, 4'b0000, 3'd0);
        ->sample_ev;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        push("post_reset_menu", 16'h0000, menu_seg(0), 4'b0000, 4'b0000, 3'd0);

        // Let the monitor drain every expectation
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
Top-level sequencer that shares the 16 LEDs, the 4-digit 7-segment display and the go/stop button between NUM_MODES game-mode blocks (mode 1..N). It runs a menu where the player picks a mode, shows a 1 s splash, then raises exactly one mode's active line and muxes that mode's led/seg_data to the board. It drops active on a back press, which returns the mode to its idle/reset state, and returns to the menu.

Parameters:
NUM_MODES, 4, number of attached mode blocks (2..9).
SPLASH_CYCLES, 100_000_000, splash duration in clk cycles (1 s at 100 MHz).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_next  in  1  debounced level; rising edge advances menu selection
btn_enter  in  1  debounced level; rising edge enters the selected mode; doubles as the in-game go/stop button
btn_back  in  1  debounced level; rising edge aborts splash or exits the running mode
mode_led_in  in  16*NUM_MODES  led bus of mode k at bits [16k+15:16k]
mode_seg_in  in  20*NUM_MODES  seg_data bus of mode k at bits [20k+19:20k]
mode_active  out  NUM_MODES  one-hot active line to each mode (all-zero outside RUN)
mode_btn  out  NUM_MODES  gated go/stop level to each mode
led  out  16  board LEDs (registered)
seg_data  out  20  four 5-bit glyph codes, leftmost digit in [19:15] (registered)
cur_mode  out  3  selected mode index, 0-based

Behaviour:
- Reset (async, any state): state=MENU, sel=0, splash counter=0, arm=0, mode_active=0, mode_btn=0, led=0, seg_data={P,BLANK,BLANK,1} = {16,31,31,1}, cur_mode=0.
- Glyph codes: digits 0-9 = 0-9; P=16; BLANK=31; d=19; n=20.
- Edge detect: each button uses a registered previous value; edge = level & ~prev. prev registers reset to 0.
- States: MENU, SPLASH, RUN, EXIT.
- MENU: led=0; seg_data={P,BLANK,BLANK,sel+1}.
  - next edge: sel=sel+1; wraps NUM_MODES-1 -> 0.
  - enter edge: go to SPLASH, counter=0.
  - enter and next edges in the same cycle: enter wins; sel unchanged.
  - back edge: ignored.
- SPLASH: led=16'hFFFF; seg_data={P,BLANK,BLANK,sel+1}. Counter increments each cycle.
  - counter==SPLASH_CYCLES-1: go to RUN; arm=0.
  - back edge: go to MENU and clear counter. Back takes priority over the counter expiring in the same cycle.
  - next/enter: ignored.
- RUN: mode_active[sel]=1, all other bits 0. led/seg_data register the selected mode's slices, giving 1-cycle latency.
  - arm sets once btn_enter is sampled low; until then mode_btn=0. This keeps the entering press from reaching the mode.
  - Once armed: mode_btn[sel]=btn_enter, all other bits 0.
  - back edge: go to EXIT. Back wins over a simultaneous enter.
- EXIT: lasts exactly 1 cycle. mode_active=0, mode_btn=0, led=0, seg_data all BLANK. Then go to MENU with sel unchanged.
- mode_active and mode_btn are registered; they change on the clock edge that enters or leaves RUN.
- cur_mode = sel in all states.
- A reset mid-RUN drops mode_active at once (async). The mode sees !active and clears itself.
- mode_led_in and mode_seg_in of non-selected modes are never observed.

Decomposition:
- Shared package game_pkg: glyph code constants (C_BLANK=31, C_P=16, C_U=15, C_d=19, C_n=20, C_g=9, C_o=17), controller state enum, default SPLASH_CYCLES. Mode blocks use the same glyph constants.
- One sub-module: btn_edge (clk, reset, level -> rise pulse), instantiated three times.

Test Plan:
- Reset, then no input -> seg_data={16,31,31,1}, led=0, mode_active=0, cur_mode=0.
- With NUM_MODES=4, 5 next edges -> sel passes 1,2,3,0,1; seg_data last digit=2; cur_mode=1.
- Enter on sel=1 with SPLASH_CYCLES=10 -> led=FFFF for exactly 10 cycles; mode_active=4'b0010 on cycle 11; led/seg follow mode 1 inputs 1 cycle later.
- In RUN, keep btn_enter held from entry -> mode_btn=0 until btn_enter falls; a subsequent press -> mode_btn[1]=1 while held, other bits 0.
- Back edge in RUN -> one EXIT cycle (mode_active=0, seg all 31), then MENU showing {16,31,31,2}. Back at splash cycle 5 -> MENU, mode_active never asserted.
- Assert reset mid-RUN -> mode_active=0 in the same cycle (async), state MENU, sel=0 after release.
